// File: rtl/vigna_axi_pkg.sv
// Shared definitions for the vigna AXI4-Lite master: FSM states, response codes
// and the response-to-error mapping used on both read and write paths.
package vigna_axi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WREQ  = 3'd3,
        WRESP = 3'd4,
        DONE  = 3'd5,
        DRAIN = 3'd6
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/vigna_axil_master_if.sv
// AXI4-Lite bus bundle (AR/R/AW/W/B channels, 32-bit data) with master and slave views.
interface vigna_axil_master_if #(
    parameter int ADDR_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    modport master (
        output arvalid, araddr, arprot, rready,
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, arprot, rready,
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/vigna_timeout_cnt.sv
// Response-wait watchdog: counts cycles while enabled, flags the last allowed cycle.
// TIMEOUT of 0 never expires.
module vigna_timeout_cnt #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (cnt == LAST);
endmodule

// File: rtl/vigna_axil_master.sv
// Core-side request/response port bridged onto AXI4-Lite, with a response timeout
// and orphan-response draining. WRITE_EN=0 gives a read-only (instruction) port.
//
// state | meaning
// IDLE  | waiting for core_valid
// RADDR | arvalid held until arready
// RDATA | rready, waiting for rvalid or timeout
// WREQ  | awvalid/wvalid, each dropped on its own ready
// WRESP | bready, waiting for bvalid or timeout
// DONE  | core_ready held until core_valid falls
// DRAIN | swallow the late response of a timed-out request
module vigna_axil_master
    import vigna_axi_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter bit         WRITE_EN = 1'b1,
    parameter int         TIMEOUT  = 256,
    parameter logic [2:0] PROT     = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_valid,
    output logic              core_ready,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [3:0]        core_wstrb,
    output logic [31:0]       core_rdata,
    output logic              core_err,
    vigna_axil_master_if.master axi
);
    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done, w_done;
    logic              orphan, orphan_wr;
    logic              aw_pend, w_pend, aw_hs, w_hs;
    logic              waiting, expired, drain_hit;

    assign aw_pend   = WRITE_EN && (state == WREQ) && !aw_done;
    assign w_pend    = WRITE_EN && (state == WREQ) && !w_done;
    assign aw_hs     = aw_pend && axi.awready;
    assign w_hs      = w_pend && axi.wready;
    assign waiting   = (state == RDATA) || (state == WRESP);
    assign drain_hit = orphan_wr ? axi.bvalid : axi.rvalid;

    vigna_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (core_valid) begin
                if (core_wstrb == 4'd0) state_nxt = RADDR;
                else if (WRITE_EN)      state_nxt = WREQ;
                else                    state_nxt = DONE;
            end
            RADDR: if (axi.arready) state_nxt = RDATA;
            RDATA: if (axi.rvalid || expired) state_nxt = DONE;
            WREQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WRESP;
            WRESP: if (axi.bvalid || expired) state_nxt = DONE;
            DONE:  if (!core_valid) state_nxt = orphan ? DRAIN : IDLE;
            DRAIN: if (drain_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            orphan     <= 1'b0;
            orphan_wr  <= 1'b0;
            core_rdata <= '0;
            core_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (core_valid) begin
                    addr_q  <= core_addr;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (core_wstrb != 4'd0) begin
                        if (WRITE_EN) begin
                            wdata_q <= core_wdata;
                            wstrb_q <= core_wstrb;
                        end else begin
                            core_err <= 1'b1;
                        end
                    end
                end
                WREQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                RDATA: if (axi.rvalid) begin
                    core_rdata <= axi.rdata;
                    core_err   <= resp_is_err(axi.rresp);
                end else if (expired) begin
                    core_rdata <= '0;
                    core_err   <= 1'b1;
                    orphan     <= 1'b1;
                    orphan_wr  <= 1'b0;
                end
                WRESP: if (axi.bvalid) begin
                    core_err <= resp_is_err(axi.bresp);
                end else if (expired) begin
                    core_rdata <= '0;
                    core_err   <= 1'b1;
                    orphan     <= 1'b1;
                    orphan_wr  <= 1'b1;
                end
                DRAIN: if (drain_hit) orphan <= 1'b0;
                default: ;
            endcase
        end
    end

    assign core_ready  = (state == DONE);

    assign axi.arvalid = (state == RADDR);
    assign axi.araddr  = addr_q;
    assign axi.arprot  = PROT;
    assign axi.rready  = (state == RDATA) || ((state == DRAIN) && !orphan_wr);

    // Write channels are held at zero on a read-only port.
    assign axi.awvalid = aw_pend;
    assign axi.awaddr  = WRITE_EN ? addr_q : '0;
    assign axi.awprot  = WRITE_EN ? PROT : 3'b000;
    assign axi.wvalid  = w_pend;
    assign axi.wdata   = WRITE_EN ? wdata_q : 32'h0;
    assign axi.wstrb   = WRITE_EN ? wstrb_q : 4'h0;
    assign axi.bready  = WRITE_EN && ((state == WRESP) || ((state == DRAIN) && orphan_wr));
endmodule

// File: tb/tb_vigna_axil_master.sv
// Bench for vigna_axil_master: the bench plays core and AXI slave, derives every
// cycle's expected outputs from the transaction phase it is driving, and compares.
module tb_vigna_axil_master;
    localparam int         TMO    = 8;
    localparam logic [2:0] PROT_V = 3'b101;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        core_valid = 1'b0, core_ready;
    logic [31:0] core_addr = '0, core_wdata = '0, core_rdata;
    logic [3:0]  core_wstrb = '0;
    logic        core_err;

    logic        i_core_valid = 1'b0, i_core_ready;
    logic [31:0] i_core_addr = '0, i_core_wdata = '0, i_core_rdata;
    logic [3:0]  i_core_wstrb = '0;
    logic        i_core_err;

    vigna_axil_master_if #(.ADDR_W(32)) ifc ();
    vigna_axil_master_if #(.ADDR_W(32)) ifc_i ();

    vigna_axil_master #(.ADDR_W(32), .WRITE_EN(1'b1), .TIMEOUT(TMO), .PROT(PROT_V)) dut (
        .clk(clk), .reset(reset),
        .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_wstrb(core_wstrb),
        .core_rdata(core_rdata), .core_err(core_err), .axi(ifc)
    );

    vigna_axil_master #(.ADDR_W(32), .WRITE_EN(1'b0), .TIMEOUT(TMO), .PROT(PROT_V)) dut_i (
        .clk(clk), .reset(reset),
        .core_valid(i_core_valid), .core_ready(i_core_ready), .core_addr(i_core_addr),
        .core_wdata(i_core_wdata), .core_wstrb(i_core_wstrb),
        .core_rdata(i_core_rdata), .core_err(i_core_err), .axi(ifc_i)
    );

    int n_pass = 0;
    int n_total = 0;

    logic        mon_en = 1'b0;
    logic        e_arvalid = 0, e_awvalid = 0, e_wvalid = 0, e_rready = 0, e_bready = 0, e_core_ready = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
    logic [3:0]  e_wstrb = '0;
    logic        e_err = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        i_bus_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("arvalid", ifc.arvalid, e_arvalid);
            chk("awvalid", ifc.awvalid, e_awvalid);
            chk("wvalid", ifc.wvalid, e_wvalid);
            chk("rready", ifc.rready, e_rready);
            chk("bready", ifc.bready, e_bready);
            chk("core_ready", core_ready, e_core_ready);
            if (e_arvalid) begin
                chk("araddr", ifc.araddr, e_addr);
                chk("arprot", ifc.arprot, PROT_V);
            end
            if (e_awvalid) begin
                chk("awaddr", ifc.awaddr, e_addr);
                chk("awprot", ifc.awprot, PROT_V);
            end
            if (e_wvalid) begin
                chk("wdata", ifc.wdata, e_wdata);
                chk("wstrb", ifc.wstrb, e_wstrb);
            end
            if (e_core_ready) begin
                chk("core_rdata", core_rdata, e_rdata);
                chk("core_err", core_err, e_err);
            end
        end
        if (ifc_i.arvalid || ifc_i.awvalid || ifc_i.wvalid) i_bus_seen = 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic ar, input logic aw, input logic w,
                           input logic r, input logic b, input logic cr);
        e_arvalid = ar; e_awvalid = aw; e_wvalid = w;
        e_rready = r; e_bready = b; e_core_ready = cr;
    endtask

    task automatic zero_slave();
        ifc.arready = 1'b0; ifc.rvalid = 1'b0; ifc.awready = 1'b0;
        ifc.wready = 1'b0; ifc.bvalid = 1'b0;
        ifc.rdata = $urandom; ifc.rresp = 2'($urandom); ifc.bresp = 2'($urandom);
    endtask

    // After the request is taken, the core-side inputs are junk; only core_valid matters.
    task automatic scramble_core(input int drop_d);
        core_valid = (drop_d >= 0);
        core_addr  = $urandom;
        core_wdata = $urandom;
        core_wstrb = 4'($urandom);
    endtask

    task automatic idle_cycles(input int n, input logic stray_b);
        for (int i = 0; i < n; i++) begin
            cyc(); zero_slave();
            core_valid = 1'b0;
            ifc.bvalid = stray_b;
            set_exp(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic done_phase(input int drop_d, input logic [31:0] rd, input logic err);
        int k;
        k = (drop_d < 0) ? 0 : drop_d;
        for (int i = 0; i <= k; i++) begin
            cyc(); zero_slave(); scramble_core(-1);
            core_valid = (i < drop_d);
            set_exp(0, 0, 0, 0, 0, 1);
            e_rdata = rd; e_err = err;
        end
    endtask

    task automatic drain(input logic is_wr, input int late_d, input logic [31:0] stall_addr);
        for (int i = 0; i <= late_d; i++) begin
            cyc(); zero_slave();
            core_valid = 1'b1; core_addr = stall_addr; core_wstrb = 4'h0;
            ifc.rvalid = !is_wr && (i == late_d);
            ifc.bvalid = is_wr && (i == late_d);
            set_exp(0, 0, 0, !is_wr, is_wr, 0);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_d, input int r_d,
                           input logic [31:0] data, input logic [1:0] resp, input int drop_d,
                           output bit tmo);
        logic [31:0] exp_rd;
        logic        exp_err;
        cyc(); zero_slave();
        core_valid = 1'b1; core_addr = addr; core_wstrb = 4'h0; core_wdata = $urandom;
        set_exp(0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= ar_d; i++) begin
            cyc(); zero_slave(); scramble_core(drop_d);
            ifc.arready = (i == ar_d);
            set_exp(1, 0, 0, 0, 0, 0);
            e_addr = addr;
        end
        tmo = (r_d >= TMO);
        for (int i = 0; i < (tmo ? TMO : r_d + 1); i++) begin
            cyc(); zero_slave(); scramble_core(drop_d);
            if (i == r_d) begin
                ifc.rvalid = 1'b1; ifc.rdata = data; ifc.rresp = resp;
            end
            set_exp(0, 0, 0, 1, 0, 0);
        end
        exp_rd  = tmo ? 32'h0 : data;
        exp_err = tmo ? 1'b1 : resp[1];
        last_rdata = exp_rd;
        done_phase(drop_d, exp_rd, exp_err);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_d, input int w_d, input int b_d, input logic [1:0] resp,
                            input int drop_d, output bit tmo);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        cyc(); zero_slave();
        core_valid = 1'b1; core_addr = addr; core_wdata = data; core_wstrb = strb;
        set_exp(0, 0, 0, 0, 0, 0);
        n = ((aw_d > w_d) ? aw_d : w_d) + 1;
        for (int i = 0; i < n; i++) begin
            cyc(); zero_slave(); scramble_core(drop_d);
            ifc.awready = (i >= aw_d);
            ifc.wready  = (i >= w_d);
            set_exp(0, i <= aw_d, i <= w_d, 0, 0, 0);
            e_addr = addr; e_wdata = data; e_wstrb = strb;
        end
        tmo = (b_d >= TMO);
        for (int i = 0; i < (tmo ? TMO : b_d + 1); i++) begin
            cyc(); zero_slave(); scramble_core(drop_d);
            if (i == b_d) begin
                ifc.bvalid = 1'b1; ifc.bresp = resp;
            end
            set_exp(0, 0, 0, 0, 1, 0);
        end
        exp_rd  = tmo ? 32'h0 : last_rdata;
        exp_err = tmo ? 1'b1 : resp[1];
        last_rdata = exp_rd;
        done_phase(drop_d, exp_rd, exp_err);
    endtask

    initial begin
        bit tmo;
        zero_slave();
        ifc_i.arready = 1'b0; ifc_i.rvalid = 1'b0; ifc_i.rdata = '0; ifc_i.rresp = '0;
        ifc_i.awready = 1'b0; ifc_i.wready = 1'b0; ifc_i.bvalid = 1'b0; ifc_i.bresp = '0;

        #1 reset = 1'b1;
        #2;
        chk("rst_arvalid", ifc.arvalid, 0);
        chk("rst_rready", ifc.rready, 0);
        chk("rst_core_ready", core_ready, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_araddr", ifc.araddr, 0);
        cyc(); cyc();
        reset = 1'b0;
        mon_en = 1'b1;
        idle_cycles(2, 1'b0);

        // Read-only port: a write request errors out in one cycle without bus traffic.
        cyc();
        i_core_valid = 1'b1; i_core_wstrb = 4'h3; i_core_addr = 32'h80; i_core_wdata = 32'h55;
        @(negedge clk); chk("ro_ready_c0", i_core_ready, 0);
        cyc();
        @(negedge clk); chk("ro_ready_c1", i_core_ready, 1); chk("ro_err", i_core_err, 1);
        cyc(); i_core_valid = 1'b0;
        @(negedge clk); chk("ro_ready_hold", i_core_ready, 1);
        cyc();
        @(negedge clk); chk("ro_ready_idle", i_core_ready, 0);

        do_read(32'h100, 2, 1, 32'hDEADBEEF, 2'b00, 3, tmo);
        do_write(32'h200, 32'h12345678, 4'hF, 3, 1, 0, 2'b10, 0, tmo);
        do_write(32'h204, 32'hA5A5A5A5, 4'h3, 0, 0, 2, 2'b00, 1, tmo);
        do_read(32'h108, 0, 0, 32'h0BADF00D, 2'b11, 0, tmo);
        do_read(32'h10C, 1, 3, 32'h13572468, 2'b01, 0, tmo);
        do_read(32'h110, 0, 2, 32'h600DCAFE, 2'b00, -1, tmo);

        do_read(32'h300, 0, 12, 32'hFFFFFFFF, 2'b00, 0, tmo);
        chk("tmo_read_flag", tmo, 1);
        drain(1'b0, 3, 32'h400);
        do_read(32'h400, 0, 0, 32'hCAFEF00D, 2'b00, 0, tmo);

        do_write(32'h500, 32'h11112222, 4'h8, 1, 2, 9, 2'b00, 0, tmo);
        drain(1'b1, 2, 32'h504);
        do_read(32'h504, 0, TMO - 1, 32'h76543210, 2'b00, 0, tmo);

        // Reset in the middle of a write response: everything goes quiet immediately.
        cyc(); zero_slave();
        core_valid = 1'b1; core_addr = 32'h600; core_wdata = 32'h9999; core_wstrb = 4'hF;
        set_exp(0, 0, 0, 0, 0, 0);
        cyc(); zero_slave(); scramble_core(0);
        ifc.awready = 1'b1; ifc.wready = 1'b1;
        set_exp(0, 1, 1, 0, 0, 0); e_addr = 32'h600; e_wdata = 32'h9999; e_wstrb = 4'hF;
        cyc(); zero_slave(); scramble_core(0);
        set_exp(0, 0, 0, 0, 1, 0);
        cyc(); zero_slave(); core_valid = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_bready", ifc.bready, 0);
        chk("mid_rst_awaddr", ifc.awaddr, 0);
        chk("mid_rst_wdata", ifc.wdata, 0);
        chk("mid_rst_core_rdata", core_rdata, 0);
        chk("mid_rst_core_err", core_err, 0);
        cyc();
        reset = 1'b0;
        last_rdata = 32'h0;
        idle_cycles(1, 1'b1);
        do_read(32'h700, 1, 1, 32'h2468ACE0, 2'b00, 0, tmo);

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a, d;
            int drop_d;
            a = $urandom & 32'hFFFF_FFFC;
            d = $urandom;
            drop_d = int'($urandom_range(0, 3)) - 1;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                         2'($urandom), drop_d, tmo);
                if (tmo) drain(1'b1, int'($urandom_range(0, 3)), a);
            end else begin
                do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                        d, 2'($urandom), drop_d, tmo);
                if (tmo) drain(1'b0, int'($urandom_range(0, 3)), a);
            end
            idle_cycles(int'($urandom_range(0, 2)), 1'b0);
        end

        idle_cycles(2, 1'b0);
        chk("ro_bus_quiet", i_bus_seen, 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
